// File: rtl/tape_recorder_rle_pkg.sv
// tape_pkg: shared types and constants for the run-length tape recorder.
// Holds the controller state encoding, the entry-width helper and the
// default clock/sample rates used as parameter defaults by the top level.
package tape_pkg;

  // Controller states: idle, capturing audio, reading an entry, replaying a run
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RECORD     = 2'd1,
    ST_PLAY_FETCH = 2'd2,
    ST_PLAY_RUN   = 2'd3
  } tape_state_t;

  // Default system clock and audio sample rate in Hz
  localparam int DEFAULT_CLK_FREQ    = 27000000;
  localparam int DEFAULT_SAMPLE_RATE = 8000;

  // One tape entry is {level, run}: a level bit on top of a run_w-bit count
  function automatic int entry_width(input int run_w);
    return run_w + 1;
  endfunction

endpackage

// File: rtl/tape_recorder_rle_tick_gen.sv
// tape_tick_gen: sample-rate divider for the tape recorder.
// Counts 0..DIVIDER-1 and pulses o_tick while the count sits at DIVIDER-1.
// i_clear restarts the count so the first tick lands exactly DIVIDER cycles
// after the clear.
module tape_tick_gen #(
  parameter int DIVIDER = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

  logic [CW-1:0] r_count;

  // Free-running modulo-DIVIDER counter with a synchronous restart
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick = (r_count == LAST);

endmodule

// File: rtl/tape_recorder_rle.sv
// tape_recorder_rle: run-length tape recorder for the ZX Spectrum core.
// Records the ULA MIC level as {level, run} entries into an inferred block
// RAM and replays them on the EAR input. Buttons are edge detected, stop has
// priority over record, which has priority over play.
// Optional build macro TAPE_LOOP_EN: playback wraps to the first entry at the
// end of tape and keeps looping until stop; without it playback ends there.
module tape_recorder_rle
  import tape_pkg::*;
#(
  parameter int CLK_FREQ    = DEFAULT_CLK_FREQ,
  parameter int SAMPLE_RATE = DEFAULT_SAMPLE_RATE,
  parameter int ADDR_W      = 12,
  parameter int RUN_W       = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              aud_out,
  output logic              aud_in,
  input  logic              btn_rec,
  input  logic              btn_play,
  input  logic              btn_stop,
  output logic              busy,
  output logic              recording,
  output logic              full,
  output logic [ADDR_W:0]   tape_len,
  output logic [ADDR_W:0]   position
);

  // DIVIDER must be at least 4 so a fetch never coincides with a tick
  localparam int DIVIDER = CLK_FREQ / SAMPLE_RATE;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int EW      = entry_width(RUN_W);

  localparam logic [RUN_W-1:0] RUN_MAX  = '1;
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [ADDR_W:0]  LEN_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  POS_LAST = (ADDR_W + 1)'(DEPTH - 1);

  tape_state_t       r_state;
  logic              r_rec_d;
  logic              r_play_d;
  logic              r_stop_d;
  logic              r_first;
  logic              r_cur_level;
  logic [RUN_W-1:0]  r_run;
  logic [RUN_W-1:0]  r_remain;
  logic [ADDR_W:0]   r_position;
  logic [ADDR_W:0]   r_tape_len;
  logic              r_aud_in;
  logic              r_full;
  logic [EW-1:0]     r_mem [DEPTH];
  logic [EW-1:0]     r_rdata;

  logic              w_rec_pulse;
  logic              w_play_pulse;
  logic              w_stop_pulse;
  logic              w_start_rec;
  logic              w_start_play;
  logic              w_tick;
  logic              w_tick_clear;
  logic              w_we;
  logic [EW-1:0]     w_wdata;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W:0]   w_pos_inc;
  logic              w_end_of_tape;

  // Remember last button levels so a held button only acts once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rec_d  <= 1'b0;
      r_play_d <= 1'b0;
      r_stop_d <= 1'b0;
    end else begin
      r_rec_d  <= btn_rec;
      r_play_d <= btn_play;
      r_stop_d <= btn_stop;
    end
  end

  assign w_rec_pulse  = btn_rec  & ~r_rec_d;
  assign w_play_pulse = btn_play & ~r_play_d;
  assign w_stop_pulse = btn_stop & ~r_stop_d;

  // Leaving idle is the only time the sample clock is re-phased
  assign w_start_rec  = (r_state == ST_IDLE) && !w_stop_pulse && w_rec_pulse;
  assign w_start_play = (r_state == ST_IDLE) && !w_stop_pulse && !w_rec_pulse &&
                        w_play_pulse && (r_tape_len != '0);
  assign w_tick_clear = w_start_rec | w_start_play;

  tape_tick_gen #(
    .DIVIDER (DIVIDER)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_tick_clear),
    .o_tick  (w_tick)
  );

  assign w_pos_inc     = r_position + 1'b1;
  assign w_end_of_tape = (w_pos_inc == r_tape_len);

  // Close the pending run on a level change, a saturated run, or a stop
  always_comb begin
    w_we    = 1'b0;
    w_wdata = {r_cur_level, r_run};
    if ((r_state == ST_RECORD) && !r_first) begin
      if (w_stop_pulse) begin
        w_we = 1'b1;
      end else if (w_tick && ((aud_out != r_cur_level) || (r_run == RUN_MAX))) begin
        w_we = 1'b1;
      end
    end
  end

  // Present the address the next fetch will need, so the RAM output is ready
  // in the cycle spent in PLAY_FETCH
  always_comb begin
    w_addr = r_position[ADDR_W-1:0];
    case (r_state)
      ST_IDLE: begin
        w_addr = '0;
      end
      ST_PLAY_RUN: begin
`ifdef TAPE_LOOP_EN
        if (w_end_of_tape) begin
          w_addr = '0;
        end else begin
          w_addr = w_pos_inc[ADDR_W-1:0];
        end
`else
        w_addr = w_pos_inc[ADDR_W-1:0];
`endif
      end
      default: begin
        w_addr = r_position[ADDR_W-1:0];
      end
    endcase
  end

  // Single-port tape RAM, read-first, one cycle read latency, never reset
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_addr] <= w_wdata;
    end
    r_rdata <= r_mem[w_addr];
  end

  // Main controller: recording, playback and button handling
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_aud_in    <= 1'b1;
      r_full      <= 1'b0;
      r_tape_len  <= '0;
      r_position  <= '0;
      r_first     <= 1'b0;
      r_cur_level <= 1'b0;
      r_run       <= '0;
      r_remain    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_aud_in <= 1'b1;
          if (w_start_rec) begin
            r_position <= '0;
            r_full     <= 1'b0;
            r_first    <= 1'b1;
            r_state    <= ST_RECORD;
          end else if (w_start_play) begin
            r_position <= '0;
            r_state    <= ST_PLAY_FETCH;
          end
        end

        ST_RECORD: begin
          if (w_stop_pulse) begin
            if (!r_first) begin
              r_tape_len <= w_pos_inc;
              r_position <= w_pos_inc;
              r_full     <= (r_position == POS_LAST);
            end else begin
              r_tape_len <= '0;
            end
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            if (r_first) begin
              r_first     <= 1'b0;
              r_cur_level <= aud_out;
              r_run       <= RUN_ONE;
            end else if (w_we) begin
              if (r_position == POS_LAST) begin
                r_tape_len <= LEN_FULL;
                r_position <= LEN_FULL;
                r_full     <= 1'b1;
                r_state    <= ST_IDLE;
              end else begin
                r_position  <= w_pos_inc;
                r_cur_level <= aud_out;
                r_run       <= RUN_ONE;
              end
            end else begin
              r_run <= r_run + 1'b1;
            end
          end
        end

        ST_PLAY_FETCH: begin
          if (w_stop_pulse) begin
            r_aud_in <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_aud_in <= r_rdata[RUN_W];
            r_remain <= r_rdata[RUN_W-1:0];
            r_state  <= ST_PLAY_RUN;
          end
        end

        ST_PLAY_RUN: begin
          if (w_stop_pulse) begin
            r_aud_in <= 1'b1;
            r_state  <= ST_IDLE;
          end else if (w_tick) begin
            if (r_remain == RUN_ONE) begin
              r_remain <= '0;
              if (w_end_of_tape) begin
`ifdef TAPE_LOOP_EN
                r_position <= '0;
                r_state    <= ST_PLAY_FETCH;
`else
                r_position <= w_pos_inc;
                r_aud_in   <= 1'b1;
                r_state    <= ST_IDLE;
`endif
              end else begin
                r_position <= w_pos_inc;
                r_state    <= ST_PLAY_FETCH;
              end
            end else begin
              r_remain <= r_remain - 1'b1;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign aud_in    = r_aud_in;
  assign busy      = (r_state != ST_IDLE);
  assign recording = (r_state == ST_RECORD);
  assign full      = r_full;
  assign tape_len  = r_tape_len;
  assign position  = r_position;

endmodule
